// File: rtl/exec_unit_if.sv
// Execute-stage handshake/operand/result bundle between issue logic and exec_unit.
interface exec_unit_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  Start;
  logic [2:0]            Op;
  logic [WIDTH-1:0]      Source1;
  logic [WIDTH-1:0]      Source2;
  logic [REG_ADDR_W-1:0] DestIn;
  logic                  Busy;
  logic                  Done;
  logic                  WriteEnable;
  logic [WIDTH-1:0]      Result;
  logic [REG_ADDR_W-1:0] Destination;
  logic                  Zero;
  logic                  Carry;

  modport master (
    output Start, Op, Source1, Source2, DestIn,
    input  Busy, Done, WriteEnable, Result, Destination, Zero, Carry
  );

  modport slave (
    input  Start, Op, Source1, Source2, DestIn,
    output Busy, Done, WriteEnable, Result, Destination, Zero, Carry
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus a WIDTH-cycle shift-add multiply,
// with a Start/Busy/Done handshake and one operation in flight.
module exec_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  exec_unit_if.slave      bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_MUL
  } op_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [SHW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [REG_ADDR_W-1:0] dest_out_q, dest_out_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;

  logic [WIDTH:0]        sum_ext;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_carry;
  logic [WIDTH-1:0]      acc_next;

  // Single-cycle ALU and the multiply partial-sum step, from latched operands.
  always_comb begin
    sum_ext   = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    acc_next  = acc_q + (b_q[0] ? a_q : '0);
    case (op_q)
      OP_ADD: begin
        sum_ext   = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLL:  alu_res = a_q << b_q[SHW-1:0];
      OP_SRL:  alu_res = a_q >> b_q[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  // Next-state, operand capture, multiply iteration and result update on entry to DONE.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    dest_d     = dest_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    dest_out_d = dest_out_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          op_d    = op_e'(bus.Op);
          a_d     = bus.Source1;
          b_d     = bus.Source2;
          dest_d  = bus.DestIn;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op_q == OP_MUL) begin
          // Multiplicand walks left, multiplier walks right; bits above WIDTH fall off.
          acc_d = acc_next;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            result_d   = acc_next;
            zero_d     = (acc_next == '0);
            carry_d    = 1'b0;
            dest_out_d = dest_q;
            state_d    = DONE;
          end
        end else begin
          result_d   = alu_res;
          zero_d     = (alu_res == '0);
          carry_d    = alu_carry;
          dest_out_d = dest_q;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      dest_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      dest_out_q <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      dest_q     <= dest_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      dest_out_q <= dest_out_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
    end
  end

  assign bus.Busy        = (state_q != IDLE);
  assign bus.Done        = (state_q == DONE);
  assign bus.WriteEnable = (state_q == DONE);
  assign bus.Result      = result_q;
  assign bus.Destination = dest_out_q;
  assign bus.Zero        = zero_q;
  assign bus.Carry       = carry_q;
endmodule
